// File: rtl/aucohl_pwm_out_stage.sv
// PWM output conditioning: complementary dead-time insertion, per-pin polarity,
// filtered fault/brake handling with glitch-free re-arm on a clean reference edge.
module aucohl_pwm_out_stage #(
    parameter int FLT_FILT = 3,
    parameter int DT_W     = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            out_en,
    input  logic            comp_en,
    input  logic            pwm0_in,
    input  logic            pwm1_in,
    input  logic [DT_W-1:0] dt_rise,
    input  logic [DT_W-1:0] dt_fall,
    input  logic [1:0]      pol,
    input  logic [1:0]      safe_lvl,
    input  logic            fault_in,
    input  logic            fault_auto,
    input  logic            fault_clr,
    output logic            pwm0_out,
    output logic            pwm1_out,
    output logic            fault_flag,
    output logic [1:0]      state
);
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        FAULT   = 2'b10,
        RECOVER = 2'b11
    } state_t;

    localparam int FW = $clog2(FLT_FILT + 1);

    state_t          cur_state, nxt_state;
    logic            flt_s1, flt_s2, flt;
    logic [FW-1:0]   flt_cnt;
    logic            ref_d, ref_rise, ref_fall;
    logic            a0, a1, a0_nxt, a1_nxt;
    logic            dt_dir, dt_dir_nxt;
    logic [DT_W-1:0] dt_cnt, dt_cnt_nxt;
    logic [1:0]      pin_nxt;

    assign ref_rise   = pwm0_in & ~ref_d;
    assign ref_fall   = ~pwm0_in & ref_d;
    assign fault_flag = (cur_state == FAULT);
    assign state      = cur_state;

    // Synchroniser plus stability filter: flt only flips after FLT_FILT agreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            flt_s1  <= 1'b0;
            flt_s2  <= 1'b0;
            flt     <= 1'b0;
            flt_cnt <= '0;
        end else begin
            flt_s1 <= fault_in;
            flt_s2 <= flt_s1;
            if (flt_s2 == flt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FLT_FILT - 1)) begin
                flt     <= flt_s2;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        nxt_state = cur_state;
        if (flt) begin
            nxt_state = FAULT;
        end else if (!out_en) begin
            nxt_state = IDLE;
        end else begin
            case (cur_state)
                IDLE:    nxt_state = RECOVER;
                FAULT:   if (fault_auto || fault_clr) nxt_state = RECOVER;
                RECOVER: if (ref_rise) nxt_state = RUN;
                default: nxt_state = RUN;
            endcase
        end
    end

    // Entry into RUN counts as a rising edge so pwm0 always gets its dead interval first.
    always_comb begin
        a0_nxt     = a0;
        a1_nxt     = a1;
        dt_dir_nxt = dt_dir;
        dt_cnt_nxt = dt_cnt;
        if (nxt_state != RUN || !comp_en) begin
            a0_nxt     = 1'b0;
            a1_nxt     = 1'b0;
            dt_dir_nxt = 1'b0;
            dt_cnt_nxt = '0;
        end else if (ref_rise || cur_state != RUN) begin
            dt_dir_nxt = 1'b1;
            dt_cnt_nxt = dt_rise;
            a0_nxt     = (dt_rise == '0);
            a1_nxt     = 1'b0;
        end else if (ref_fall) begin
            dt_dir_nxt = 1'b0;
            dt_cnt_nxt = dt_fall;
            a0_nxt     = 1'b0;
            a1_nxt     = (dt_fall == '0);
        end else if (dt_cnt != '0) begin
            dt_cnt_nxt = dt_cnt - 1'b1;
            if (dt_cnt == DT_W'(1)) begin
                a0_nxt = dt_dir;
                a1_nxt = ~dt_dir;
            end
        end
    end

    always_comb begin
        pin_nxt = safe_lvl;
        if (nxt_state == RUN) begin
            pin_nxt = comp_en ? ({a1_nxt, a0_nxt} ^ pol) : ({pwm1_in, pwm0_in} ^ pol);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= IDLE;
            ref_d     <= 1'b0;
            a0        <= 1'b0;
            a1        <= 1'b0;
            dt_dir    <= 1'b0;
            dt_cnt    <= '0;
            pwm0_out  <= 1'b0;
            pwm1_out  <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            ref_d     <= pwm0_in;
            a0        <= a0_nxt;
            a1        <= a1_nxt;
            dt_dir    <= dt_dir_nxt;
            dt_cnt    <= dt_cnt_nxt;
            pwm0_out  <= pin_nxt[0];
            pwm1_out  <= pin_nxt[1];
        end
    end
endmodule

// File: tb/tb_aucohl_pwm_out_stage.sv
// Scoreboard bench for aucohl_pwm_out_stage: a cycle model pushes expected pins/state
// each cycle, and each scenario task pops and compares after the clock edge.
module tb_aucohl_pwm_out_stage;
    localparam int FF = 3;
    localparam int HW = FF + 2;
    localparam logic [1:0] ST_IDLE = 2'b00, ST_RUN = 2'b01, ST_FAULT = 2'b10, ST_RECOVER = 2'b11;

    logic       clk = 1'b0;
    logic       rst, out_en, comp_en, pwm0_in, pwm1_in;
    logic [7:0] dt_rise, dt_fall;
    logic [1:0] pol, safe_lvl;
    logic       fault_in, fault_auto, fault_clr;
    logic       pwm0_out, pwm1_out, fault_flag;
    logic [1:0] state;

    typedef struct packed {
        logic [1:0] pins;
        logic [1:0] st;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    logic [HW-1:0] m_hist;
    logic          m_flt, m_prev;
    logic [1:0]    m_st;
    int            m_dir, m_since, m_dt;

    aucohl_pwm_out_stage #(.FLT_FILT(FF), .DT_W(8)) dut (
        .clk(clk), .rst(rst), .out_en(out_en), .comp_en(comp_en),
        .pwm0_in(pwm0_in), .pwm1_in(pwm1_in), .dt_rise(dt_rise), .dt_fall(dt_fall),
        .pol(pol), .safe_lvl(safe_lvl), .fault_in(fault_in), .fault_auto(fault_auto),
        .fault_clr(fault_clr), .pwm0_out(pwm0_out), .pwm1_out(pwm1_out),
        .fault_flag(fault_flag), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    // Reference model: fault accepted once the last FF synchronised samples all disagree
    // with the current verdict; dead time expressed as cycles elapsed since the last edge.
    task automatic model_step();
        exp_t       e;
        logic [1:0] nst;
        logic       rise, fall, a0, a1;
        if (rst) begin
            m_hist = '0; m_flt = 1'b0; m_prev = 1'b0; m_st = ST_IDLE;
            m_dir = 0; m_since = 0; m_dt = 0;
            e.pins = 2'b00; e.st = ST_IDLE;
            exp_q.push_back(e);
            return;
        end
        rise = pwm0_in & ~m_prev;
        fall = ~pwm0_in & m_prev;
        if (m_flt) nst = ST_FAULT;
        else if (!out_en) nst = ST_IDLE;
        else if (m_st == ST_IDLE) nst = ST_RECOVER;
        else if (m_st == ST_FAULT) nst = (fault_auto || fault_clr) ? ST_RECOVER : ST_FAULT;
        else if (m_st == ST_RECOVER) nst = rise ? ST_RUN : ST_RECOVER;
        else nst = ST_RUN;
        if (nst != ST_RUN || !comp_en) m_dir = 0;
        else if (m_st != ST_RUN || rise) begin m_dir = 1; m_since = 0; m_dt = int'(dt_rise); end
        else if (fall) begin m_dir = 2; m_since = 0; m_dt = int'(dt_fall); end
        else m_since++;
        a0 = (m_dir == 1) && (m_since >= m_dt);
        a1 = (m_dir == 2) && (m_since >= m_dt);
        if (nst != ST_RUN) e.pins = safe_lvl;
        else if (comp_en) e.pins = {a1, a0} ^ pol;
        else e.pins = {pwm1_in, pwm0_in} ^ pol;
        e.st = nst;
        exp_q.push_back(e);
        m_hist = {m_hist[HW-2:0], fault_in};
        if (m_hist[HW-1:2] == {FF{~m_flt}}) m_flt = ~m_flt;
        m_prev = pwm0_in;
        m_st   = nst;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({pwm1_out, pwm0_out} !== e.pins || state !== e.st || fault_flag !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset cyc=%0d pins=%b exp=%b state=%b exp=%b flag=%b",
                         cyc, {pwm1_out, pwm0_out}, e.pins, state, e.st, fault_flag);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_complementary();
        exp_t e;
        logic nv, last0, last1;
        int   rise_cyc, fall_cyc;
        out_en = 1'b1; comp_en = 1'b1; dt_rise = 8'd4; dt_fall = 8'd2; pol = 2'b00; safe_lvl = 2'b00;
        rise_cyc = 0; fall_cyc = 0;
        last0 = pwm0_out; last1 = pwm1_out;
        for (int i = 0; i < 70; i++) begin
            nv = (i >= 5) && (((i - 5) % 20) < 10);
            if (nv && !pwm0_in) rise_cyc = cyc;
            if (!nv && pwm0_in) fall_cyc = cyc;
            pwm0_in = nv;
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({pwm1_out, pwm0_out} !== e.pins || state !== e.st || fault_flag !== (e.st == ST_FAULT)) begin
                errors++;
                $display("[TB] FAIL comp cyc=%0d pins=%b exp=%b state=%b exp=%b",
                         cyc, {pwm1_out, pwm0_out}, e.pins, state, e.st);
            end
            checks++;
            if (pwm0_out === 1'b1 && pwm1_out === 1'b1) begin
                errors++;
                $display("[TB] FAIL comp_overlap cyc=%0d pins=11 exp=never both high", cyc);
            end
            if (i == 5) begin
                checks++;
                if (state !== ST_RUN) begin
                    errors++;
                    $display("[TB] FAIL comp_enter_run cyc=%0d state=%b exp=%b", cyc, state, ST_RUN);
                end
            end
            if (pwm0_out === 1'b1 && last0 === 1'b0) begin
                checks++;
                if (cyc - rise_cyc != 5) begin
                    errors++;
                    $display("[TB] FAIL comp_rise_lat cyc=%0d got=%0d exp=5", cyc, cyc - rise_cyc);
                end
            end
            if (pwm1_out === 1'b1 && last1 === 1'b0) begin
                checks++;
                if (cyc - fall_cyc != 3) begin
                    errors++;
                    $display("[TB] FAIL comp_fall_lat cyc=%0d got=%0d exp=3", cyc, cyc - fall_cyc);
                end
            end
            last0 = pwm0_out; last1 = pwm1_out;
        end
    endtask

    task automatic test_glitch_pulse();
        exp_t e;
        logic nv, last1;
        int   fall_cyc;
        dt_rise = 8'd6; dt_fall = 8'd2;
        fall_cyc = 0; last1 = pwm1_out;
        for (int i = 0; i < 25; i++) begin
            nv = (i >= 8) && (i < 11);
            if (!nv && pwm0_in) fall_cyc = cyc;
            pwm0_in = nv;
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({pwm1_out, pwm0_out} !== e.pins || state !== e.st) begin
                errors++;
                $display("[TB] FAIL glitch cyc=%0d pins=%b exp=%b state=%b exp=%b",
                         cyc, {pwm1_out, pwm0_out}, e.pins, state, e.st);
            end
            checks++;
            if (pwm0_out !== 1'b0) begin
                errors++;
                $display("[TB] FAIL glitch_pwm0 cyc=%0d pwm0_out=%b exp=0", cyc, pwm0_out);
            end
            if (i > 11 && pwm1_out === 1'b1 && last1 === 1'b0) begin
                checks++;
                if (cyc - fall_cyc != 3) begin
                    errors++;
                    $display("[TB] FAIL glitch_fall_lat cyc=%0d got=%0d exp=3", cyc, cyc - fall_cyc);
                end
            end
            last1 = pwm1_out;
        end
    endtask

    task automatic test_fault_filter();
        exp_t e;
        for (int i = 0; i < 12; i++) begin
            fault_in = (i < 2);
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({pwm1_out, pwm0_out} !== e.pins || state !== e.st || state !== ST_RUN) begin
                errors++;
                $display("[TB] FAIL fault_filter cyc=%0d pins=%b exp=%b state=%b exp=%b",
                         cyc, {pwm1_out, pwm0_out}, e.pins, state, ST_RUN);
            end
        end
    endtask

    task automatic test_fault_latched();
        exp_t e;
        safe_lvl = 2'b10; fault_auto = 1'b0;
        for (int i = 0; i < 32; i++) begin
            fault_in  = (i < 10);
            fault_clr = (i == 8) || (i == 22);
            pwm0_in   = (i >= 26);
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({pwm1_out, pwm0_out} !== e.pins || state !== e.st || fault_flag !== (e.st == ST_FAULT)) begin
                errors++;
                $display("[TB] FAIL fault_latch cyc=%0d pins=%b exp=%b state=%b exp=%b flag=%b",
                         cyc, {pwm1_out, pwm0_out}, e.pins, state, e.st, fault_flag);
            end
            if (i == 5 || i == 20) begin
                checks++;
                if (state !== ST_FAULT || {pwm1_out, pwm0_out} !== 2'b10 || fault_flag !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL fault_hold i=%0d state=%b pins=%b exp=FAULT/10", i, state, {pwm1_out, pwm0_out});
                end
            end
            if (i == 23 || i == 26) begin
                checks++;
                if (state !== ((i == 23) ? ST_RECOVER : ST_RUN)) begin
                    errors++;
                    $display("[TB] FAIL fault_rearm i=%0d state=%b exp=%b", i, state, (i == 23) ? ST_RECOVER : ST_RUN);
                end
            end
        end
        fault_clr = 1'b0;
    endtask

    task automatic test_fault_auto();
        exp_t e;
        fault_auto = 1'b1; safe_lvl = 2'b01; pwm0_in = 1'b0;
        for (int i = 0; i < 18; i++) begin
            fault_in = (i < 8);
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({pwm1_out, pwm0_out} !== e.pins || state !== e.st) begin
                errors++;
                $display("[TB] FAIL fault_auto cyc=%0d pins=%b exp=%b state=%b exp=%b",
                         cyc, {pwm1_out, pwm0_out}, e.pins, state, e.st);
            end
            if (i == 12 || i == 13) begin
                checks++;
                if (state !== ((i == 12) ? ST_FAULT : ST_RECOVER)) begin
                    errors++;
                    $display("[TB] FAIL fault_auto_exit i=%0d state=%b exp=%b", i, state, (i == 12) ? ST_FAULT : ST_RECOVER);
                end
            end
        end
        fault_auto = 1'b0;
    endtask

    task automatic test_passthrough();
        exp_t e;
        logic p0, p1;
        comp_en = 1'b0; pol = 2'b11; safe_lvl = 2'b01;
        for (int i = 0; i < 28; i++) begin
            p0 = (i == 0) ? 1'b0 : (i == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            p1 = 1'($urandom_range(0, 1));
            pwm0_in = p0; pwm1_in = p1;
            out_en  = (i < 20);
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({pwm1_out, pwm0_out} !== e.pins || state !== e.st) begin
                errors++;
                $display("[TB] FAIL pass cyc=%0d pins=%b exp=%b state=%b exp=%b",
                         cyc, {pwm1_out, pwm0_out}, e.pins, state, e.st);
            end
            if (i >= 1 && i < 20) begin
                checks++;
                if (state !== ST_RUN || {pwm1_out, pwm0_out} !== ~{p1, p0}) begin
                    errors++;
                    $display("[TB] FAIL pass_invert i=%0d pins=%b exp=%b state=%b", i, {pwm1_out, pwm0_out}, ~{p1, p0}, state);
                end
            end
            if (i == 20) begin
                checks++;
                if (state !== ST_IDLE || {pwm1_out, pwm0_out} !== 2'b01) begin
                    errors++;
                    $display("[TB] FAIL pass_disable state=%b pins=%b exp=IDLE/01", state, {pwm1_out, pwm0_out});
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        out_en = 1'b1; comp_en = 1'b1; dt_rise = 8'd1; dt_fall = 8'd1; pol = 2'b01; safe_lvl = 2'b11;
        pwm1_in = 1'b0;
        for (int i = 0; i < 18; i++) begin
            pwm0_in = ((i % 6) >= 3);
            rst     = (i == 16);
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({pwm1_out, pwm0_out} !== e.pins || state !== e.st) begin
                errors++;
                $display("[TB] FAIL reset_mid cyc=%0d pins=%b exp=%b state=%b exp=%b",
                         cyc, {pwm1_out, pwm0_out}, e.pins, state, e.st);
            end
            if (i == 16) begin
                checks++;
                if ({pwm1_out, pwm0_out} !== 2'b00 || state !== ST_IDLE || fault_flag !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL reset_mid_clear pins=%b state=%b flag=%b exp=00/IDLE/0",
                             {pwm1_out, pwm0_out}, state, fault_flag);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; out_en = 1'b0; comp_en = 1'b0; pwm0_in = 1'b0; pwm1_in = 1'b0;
        dt_rise = '0; dt_fall = '0; pol = '0; safe_lvl = '0;
        fault_in = 1'b0; fault_auto = 1'b0; fault_clr = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_complementary();
        test_glitch_pulse();
        test_fault_filter();
        test_fault_latched();
        test_fault_auto();
        test_passthrough();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/aucohl_pwm_out_stage.md
Name: aucohl_pwm_out_stage

Overview:
Output conditioning stage placed directly downstream of the 32-bit timer/PWM block; it consumes the timer's raw pwm0/pwm1 levels. It inserts asymmetric dead time for complementary half-bridge drive, applies per-pin polarity, and handles a synchronised fault/brake input. The fault path forces pins to programmed safe levels and re-arms glitch-free on a clean PWM edge. Its outputs go straight to pads.

Parameters:
FLT_FILT, 3, consecutive cycles the synchronised fault must be stable before it is accepted (1..15)
DT_W, 8, width of dead-time counters and dt_rise/dt_fall

Ports:
clk  in  1  block clock, same domain as timer
rst  in  1  synchronous active-high reset
out_en  in  1  output stage enable
comp_en  in  1  1: complementary mode (pwm1 derived from pwm0_in); 0: independent pass-through
pwm0_in  in  1  raw PWM0 from timer
pwm1_in  in  1  raw PWM1 from timer (ignored when comp_en=1)
dt_rise  in  DT_W  dead cycles before pwm0 asserts
dt_fall  in  DT_W  dead cycles before pwm1 asserts
pol  in  2  per-pin inversion: [0] pwm0_out, [1] pwm1_out
safe_lvl  in  2  pin levels in IDLE/FAULT/RECOVER, post-polarity: [0] pwm0, [1] pwm1
fault_in  in  1  asynchronous fault, active-high
fault_auto  in  1  1: leave FAULT automatically when fault clears
fault_clr  in  1  one-cycle strobe to clear a latched fault
pwm0_out  out  1  conditioned PWM0 pin
pwm1_out  out  1  conditioned PWM1 pin
fault_flag  out  1  high while state is FAULT
state  out  2  00 IDLE, 01 RUN, 10 FAULT, 11 RECOVER

Behaviour:
- Reset: state=IDLE, pwm0_out=0, pwm1_out=0, fault_flag=0, counters=0, sync/filter flops=0. Pin outputs are registered.
- Fault path: fault_in passes through a 2-flop synchroniser, then a FLT_FILT-cycle stability filter. flt (accepted fault) changes only after FLT_FILT equal consecutive synchronised samples.
- Worst-case fault-to-pin latency: 2 + FLT_FILT + 1 cycles.
- State transitions, priority top-down:
  - Any state, flt=1 -> FAULT.
  - out_en=0 -> IDLE.
  - IDLE, out_en=1 -> RECOVER.
  - FAULT, flt=0 and (fault_auto=1 or fault_clr=1) -> RECOVER. fault_clr is ignored while flt=1 and is not remembered.
  - RECOVER -> RUN on the first rising edge of the reference. The reference is pwm0_in, compared against its 1-cycle-delayed copy.
- IDLE/FAULT/RECOVER: pins = safe_lvl exactly; pol is not applied to safe levels.
- RUN, comp_en=0: pin0 = pwm0_in ^ pol[0], pin1 = pwm1_in ^ pol[1]. Latency is 1 cycle; no dead time is applied.
- RUN, comp_en=1, internal (a0,a1) before polarity:
  - Reference rise: a0=a1=0 for dt_rise cycles, then a0=1.
  - Reference fall: a0=a1=0 for dt_fall cycles, then a1=1.
  - dt=0 means the new level takes effect 1 cycle after the input edge. dt=N means N cycles of both-low, then the level, i.e. N+1 cycles after the edge.
  - An edge arriving during a dead interval restarts the counter with the new direction's value. a0 and a1 are never 1 simultaneously (invariant).
  - Entry to RUN from RECOVER is treated as a rising edge, so a dt_rise interval precedes the first pwm0 assertion.
- Pins in RUN: pwm0_out = a0 ^ pol[0], pwm1_out = a1 ^ pol[1].
- dt_rise/dt_fall are sampled when each dead interval starts; mid-interval changes do not affect the current interval.
- Reset asserted mid-operation returns all outputs to 0 the cycle after the reset edge.

Test Plan:
- Reset, out_en=1, comp_en=1, dt_rise=4, dt_fall=2, pol=0, 10-high/10-low pwm0_in square wave:
  - -> first rising edge moves RECOVER->RUN; pwm0_out rises 5 cycles after the edge.
  - -> pwm1_out rises 3 cycles after each fall.
  - -> pins are never both 1.
- comp_en=1, dt_rise=6, pwm0_in high pulse of 3 cycles:
  - -> pwm0_out stays 0 throughout.
  - -> dead interval restarts on the fall; pwm1_out rises 3 cycles after the fall (dt_fall=2).
- In RUN, fault_in high for 2 cycles with FLT_FILT=3 -> no state change.
- In RUN, fault_in held high for 10 cycles, safe_lvl=2'b10, fault_auto=0:
  - -> state=FAULT and pins=(0,1) by cycle 6 after assertion.
  - -> fault_clr while still faulted is ignored.
  - -> fault_clr after release goes to RECOVER, then RUN on the next pwm0_in rise.
- fault_auto=1: release fault -> RECOVER once flt clears, with no fault_clr needed.
- comp_en=0, pol=2'b11, out_en toggled 1->0 mid-period:
  - -> pins = inverted inputs with 1-cycle latency.
  - -> on out_en=0, state=IDLE and pins=safe_lvl the next cycle.
